rt_fragment_fifo: RTL and testbench
===================================

RT_FRAGMENT_FIFO -- requirements
Module: rt_fragment_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter DW, default 32, meaning fragment data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clear, input, 1, synchronous flush of FIFO and frame counters.
REQ-006 SHALL have port s_valid, input, 1, upstream fragment valid.
REQ-007 SHALL have port s_ready, output, 1, fragment accepted when s_valid and s_ready are both high.
REQ-008 SHALL have port s_data, input, DW, fragment payload.
REQ-009 SHALL have port s_last, input, 1, final fragment of the frame.
REQ-010 SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tdata (output, DW) and m_axis_tlast (output, 1), forming the AXI-Stream master.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse on the tlast beat handshake.
REQ-012 SHALL have port frame_len, output, 32, beat count of the last completed frame.
REQ-013 SHALL have port frame_count, output, 16, completed frames, wrapping modulo 2^16.
REQ-014 SHALL have port stall_cycles, output, 32, backpressure statistic (see Configuration).

Function
REQ-015 SHALL store {s_last, s_data} in a DEPTH-entry circular buffer with read/write pointers of clog2(DEPTH)+1 bits.
REQ-016 SHALL drive s_ready = !full, combinationally from registered state only, with no dependence on m_axis_tready.
REQ-017 SHALL drive m_axis_tvalid = !empty, and SHALL take tdata/tlast from the head entry.
REQ-018 SHALL deliver a fragment accepted at cycle N into an empty FIFO on m_axis_tvalid at cycle N+1, with no combinational bypass.
REQ-019 SHALL hold tdata and tlast stable while tvalid is high and tready is low.
REQ-020 SHALL perform push and pop in the same cycle when both handshakes occur, leaving occupancy unchanged; when full, the pop frees the entry only from the next cycle.
REQ-021 SHALL wrap both pointers modulo DEPTH and distinguish full from empty by the pointer MSB.
REQ-022 SHALL increment an internal beat counter on each output handshake.
REQ-023 SHALL, on a handshake with tlast=1: latch beat counter+1 into frame_len, reset the beat counter to 0, increment frame_count, and pulse frame_done for exactly that cycle.
REQ-024 SHALL, on clear, empty the FIFO, zero the beat counter, and suppress frame_done in that cycle; frame_len and frame_count are held.
REQ-025 SHALL give clear priority over a simultaneous push or pop: that push is dropped and that pop is not counted.
REQ-026 SHALL saturate the beat counter at 2^32-1.

Reset
REQ-027 SHALL, while resetn is low, asynchronously force: pointers 0, s_ready=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_done=0, frame_len=0, frame_count=0, stall_cycles=0.
REQ-028 SHALL discard any in-flight fragments when reset is asserted mid-frame, and SHALL restart cleanly on the first clk edge after resetn rises.

Configuration
REQ-029 SHALL, with macro RT_FRAG_STALL_CNT_EN defined, increment stall_cycles in every cycle with m_axis_tvalid=1 and m_axis_tready=0, saturating at 2^32-1; clear zeroes it.
REQ-030 SHALL, without RT_FRAG_STALL_CNT_EN, tie stall_cycles to constant 0 and contain no counter logic.

Verification
REQ-031 Single fragment: push 0xDEADBEEF with s_last=1 while tready=1 -> tvalid high the next cycle with tdata 0xDEADBEEF and tlast=1; frame_done pulses; frame_len=1; frame_count=1.
REQ-032 Fill: hold tready=0 and push 8 fragments (DEPTH=8) -> s_ready low after the 8th; a 9th attempt is not accepted; with the stats macro, stall_cycles counts the tvalid-high cycles.
REQ-033 Full with simultaneous events: FIFO full, tready=1, s_valid=1 -> only a pop that cycle; the push is accepted the next cycle; order is preserved.
REQ-034 Frame of 12 fragments with random tready and s_valid -> output order matches input; tlast only on beat 12; frame_len=12; frame_done fires once.
REQ-035 Clear mid-frame with 3 entries queued plus a simultaneous push -> tvalid=0 next cycle, no frame_done, frame_count unchanged.
REQ-036 resetn low mid-frame with FIFO half full -> all outputs at their reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/rt_fragment_fifo.sv
// Fragment FIFO feeding an AXI-Stream master, with per-frame beat length and frame count.
// Define RT_FRAG_STALL_CNT_EN to build the backpressure stall-cycle counter.
module rt_fragment_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tlast,
    output logic          frame_done,
    output logic [31:0]   frame_len,
    output logic [15:0]   frame_count,
    output logic [31:0]   stall_cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DW:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] beat_cnt;
    logic [DW:0] head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Same index with differing wrap bits means the writer lapped the reader.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign s_ready       = !full;
    assign m_axis_tvalid = !empty;
    assign head          = mem[rd_ptr[AW-1:0]];
    assign m_axis_tdata  = empty ? '0 : head[DW-1:0];
    assign m_axis_tlast  = empty ? 1'b0 : head[DW];

    assign push       = s_valid && s_ready && !clear;
    assign pop        = m_axis_tvalid && m_axis_tready && !clear;
    assign frame_done = pop && m_axis_tlast;

    // Payload storage carries no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s_last, s_data};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            beat_cnt    <= '0;
            frame_len   <= '0;
            frame_count <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                if (m_axis_tlast) begin
                    frame_len   <= sat_inc32(beat_cnt);
                    beat_cnt    <= '0;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    beat_cnt <= sat_inc32(beat_cnt);
                end
            end
        end
    end

`ifdef RT_FRAG_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q <= '0;
        end else if (clear) begin
            stall_q <= '0;
        end else if (m_axis_tvalid && !m_axis_tready) begin
            stall_q <= sat_inc32(stall_q);
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_rt_fragment_fifo.sv
// Randomized bench for rt_fragment_fifo against a queue-based frame model.
module tb_rt_fragment_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          clear;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          frame_done;
    logic [31:0]   frame_len;
    logic [15:0]   frame_count;
    logic [31:0]   stall_cycles;

    rt_fragment_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .resetn(resetn), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done), .frame_len(frame_len),
        .frame_count(frame_count), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue of {last, data} plus frame statistics.
    logic [DW:0] mq[$];
    logic [31:0] m_beat  = 0;
    logic [31:0] m_len   = 0;
    logic [15:0] m_cnt   = 0;
    logic [31:0] m_stall = 0;

    function automatic logic exp_done();
        if (mq.size() == 0) return 1'b0;
        return m_axis_tready && mq[0][DW] && !clear;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_beat = 0; m_len = 0; m_cnt = 0; m_stall = 0;
    endtask

    task automatic tick();
        bit do_pop, do_push;
        do_pop  = (mq.size() > 0) && m_axis_tready;
        do_push = s_valid && (mq.size() < DEPTH);
        if (clear) begin
            mq.delete();
            m_beat = 0;
            m_stall = 0;
        end else begin
`ifdef RT_FRAG_STALL_CNT_EN
            if (mq.size() > 0 && !m_axis_tready) m_stall = m_stall + 1;
`endif
            if (do_pop) begin
                if (mq[0][DW]) begin
                    m_len = m_beat + 1;
                    m_cnt = m_cnt + 1;
                    m_beat = 0;
                end else begin
                    m_beat = m_beat + 1;
                end
                void'(mq.pop_front());
            end
            if (do_push) mq.push_back({s_last, s_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 0; s_valid = 0; s_data = '0; s_last = 0; m_axis_tready = 0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        n_cmp++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (frame_len !== 32'd0) begin n_fail++; $display("FAIL reset_frame_len: got %0d want 0", frame_len); end
        n_cmp++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        s_valid = 1; s_data = 32'hDEADBEEF; s_last = 1; m_axis_tready = 1;
        #2;
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", m_axis_tvalid); end
        tick();
        s_valid = 0;
        #2;
        n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_tvalid: got %b want 1", m_axis_tvalid); end
        n_cmp++; if (m_axis_tdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_tdata: got %h want deadbeef", m_axis_tdata); end
        n_cmp++; if (m_axis_tlast !== 1'b1) begin n_fail++; $display("FAIL single_tlast: got %b want 1", m_axis_tlast); end
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL single_frame_done: got %b want 1", frame_done); end
        tick();
        #2;
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", frame_done); end
        n_cmp++; if (frame_len !== 32'd1) begin n_fail++; $display("FAIL single_frame_len: got %0d want 1", frame_len); end
        n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL single_frame_count: got %0d want 1", frame_count); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_fill();
        m_axis_tready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1; s_data = $urandom; s_last = 0;
            #2;
            n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b want 1", i, s_ready); end
            tick();
        end
        s_valid = 1; s_data = 32'hA5A5_0009; s_last = 1;
        #2;
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got %b want 0", s_ready); end
        tick();
        #2;
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ninth_rejected: got %b want 0", s_ready); end
        n_cmp++; if (m_axis_tdata !== mq[0][DW-1:0]) begin n_fail++; $display("FAIL fill_head_stable: got %h want %h", m_axis_tdata, mq[0][DW-1:0]); end
        n_cmp++; if (stall_cycles !== m_stall) begin n_fail++; $display("FAIL fill_stall: got %0d want %0d", stall_cycles, m_stall); end
    endtask

    task automatic test_full_simul();
        int guard;
        m_axis_tready = 1;
        #2;
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fullsim_ready: got %b want 0", s_ready); end
        n_cmp++; if (m_axis_tdata !== mq[0][DW-1:0]) begin n_fail++; $display("FAIL fullsim_head: got %h want %h", m_axis_tdata, mq[0][DW-1:0]); end
        tick();
        #2;
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL fullsim_ready_after_pop: got %b want 1", s_ready); end
        tick();
        s_valid = 0;
        guard = 0;
        while (mq.size() > 0 && guard < 40) begin
            #2;
            n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mq[0][DW-1:0] || m_axis_tlast !== mq[0][DW])
                begin n_fail++; $display("FAIL fullsim_order: got %b/%h/%b want 1/%h/%b", m_axis_tvalid, m_axis_tdata, m_axis_tlast, mq[0][DW-1:0], mq[0][DW]); end
            n_cmp++; if (frame_done !== exp_done()) begin n_fail++; $display("FAIL fullsim_done: got %b want %b", frame_done, exp_done()); end
            tick();
            guard++;
        end
        #2;
        n_cmp++; if (mq.size() != 0 || m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL fullsim_drain: got tvalid %b want 0", m_axis_tvalid); end
        n_cmp++; if (frame_len !== 32'd9) begin n_fail++; $display("FAIL fullsim_frame_len: got %0d want 9", frame_len); end
        n_cmp++; if (frame_count !== m_cnt) begin n_fail++; $display("FAIL fullsim_frame_count: got %0d want %0d", frame_count, m_cnt); end
    endtask

    task automatic test_frame12();
        logic [DW-1:0] dat [12];
        logic [15:0]   cnt0;
        int sent, got, dones, cyc;
        for (int i = 0; i < 12; i++) dat[i] = $urandom;
        cnt0 = m_cnt;
        sent = 0; got = 0; dones = 0; cyc = 0;
        while ((sent < 12 || mq.size() > 0) && cyc < 1000) begin
            s_valid = (sent < 12) && ($urandom_range(0, 1) == 1);
            s_data  = (sent < 12) ? dat[sent] : '0;
            s_last  = (sent == 11);
            m_axis_tready = ($urandom_range(0, 1) == 1);
            #2;
            n_cmp++; if (m_axis_tvalid !== (mq.size() > 0)) begin n_fail++; $display("FAIL f12_tvalid: got %b want %b", m_axis_tvalid, mq.size() > 0); end
            n_cmp++; if (frame_done !== exp_done()) begin n_fail++; $display("FAIL f12_done: got %b want %b", frame_done, exp_done()); end
            if (m_axis_tvalid && m_axis_tready) begin
                n_cmp++; if (m_axis_tdata !== dat[got] || m_axis_tlast !== (got == 11))
                    begin n_fail++; $display("FAIL f12_beat_%0d: got %h/%b want %h/%b", got, m_axis_tdata, m_axis_tlast, dat[got], got == 11); end
                got++;
            end
            if (frame_done) dones++;
            if (s_valid && mq.size() < DEPTH) sent++;
            tick();
            cyc++;
        end
        idle_inputs();
        #2;
        n_cmp++; if (sent != 12 || got != 12) begin n_fail++; $display("FAIL f12_timeout: got sent %0d out %0d want 12/12", sent, got); end
        n_cmp++; if (dones != 1) begin n_fail++; $display("FAIL f12_done_count: got %0d want 1", dones); end
        n_cmp++; if (frame_len !== 32'd12) begin n_fail++; $display("FAIL f12_frame_len: got %0d want 12", frame_len); end
        n_cmp++; if (frame_count !== cnt0 + 16'd1) begin n_fail++; $display("FAIL f12_frame_count: got %0d want %0d", frame_count, cnt0 + 16'd1); end
    endtask

    task automatic test_clear();
        logic [15:0] cnt0;
        logic [31:0] len0;
        m_axis_tready = 0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; s_data = 32'hC0DE_0000 + i; s_last = (i == 1);
            tick();
        end
        s_valid = 0; m_axis_tready = 1;
        tick();
        cnt0 = frame_count; len0 = frame_len;
        clear = 1; s_valid = 1; s_data = 32'h1234_5678; s_last = 1; m_axis_tready = 1;
        #2;
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL clear_done_suppressed: got %b want 0", frame_done); end
        tick();
        clear = 0; s_valid = 0;
        #2;
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL clear_tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL clear_s_ready: got %b want 1", s_ready); end
        n_cmp++; if (frame_count !== cnt0) begin n_fail++; $display("FAIL clear_frame_count: got %0d want %0d", frame_count, cnt0); end
        n_cmp++; if (frame_len !== len0) begin n_fail++; $display("FAIL clear_frame_len: got %0d want %0d", frame_len, len0); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL clear_stall: got %0d want 0", stall_cycles); end
        s_valid = 1; s_data = 32'h0000_00F1; s_last = 1;
        tick();
        s_valid = 0;
        #2;
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL clear_next_done: got %b want 1", frame_done); end
        tick();
        #2;
        n_cmp++; if (frame_len !== 32'd1) begin n_fail++; $display("FAIL clear_beat_zeroed: got %0d want 1", frame_len); end
    endtask

    task automatic test_random_stream();
        for (int c = 0; c < 400; c++) begin
            clear   = ($urandom_range(0, 49) == 0);
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = $urandom;
            s_last  = ($urandom_range(0, 3) == 0);
            m_axis_tready = ($urandom_range(0, 2) != 0);
            #2;
            n_cmp++; if (s_ready !== (mq.size() < DEPTH) || m_axis_tvalid !== (mq.size() > 0))
                begin n_fail++; $display("FAIL rnd_flags_%0d: got %b/%b want %b/%b", c, s_ready, m_axis_tvalid, mq.size() < DEPTH, mq.size() > 0); end
            if (mq.size() > 0) begin
                n_cmp++; if (m_axis_tdata !== mq[0][DW-1:0] || m_axis_tlast !== mq[0][DW])
                    begin n_fail++; $display("FAIL rnd_head_%0d: got %h/%b want %h/%b", c, m_axis_tdata, m_axis_tlast, mq[0][DW-1:0], mq[0][DW]); end
            end
            n_cmp++; if (frame_done !== exp_done()) begin n_fail++; $display("FAIL rnd_done_%0d: got %b want %b", c, frame_done, exp_done()); end
            n_cmp++; if (frame_len !== m_len || frame_count !== m_cnt || stall_cycles !== m_stall)
                begin n_fail++; $display("FAIL rnd_stats_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c, frame_len, frame_count, stall_cycles, m_len, m_cnt, m_stall); end
            tick();
        end
        idle_inputs();
        clear = 1;
        tick();
        clear = 0;
    endtask

    task automatic test_async_reset();
        m_axis_tready = 0;
        for (int i = 0; i < DEPTH / 2; i++) begin
            s_valid = 1; s_data = $urandom; s_last = 0;
            tick();
        end
        s_valid = 0; m_axis_tready = 1;
        resetn = 0;
        #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL arst_s_ready: got %b want 1", s_ready); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL arst_tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tdata !== '0 || m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL arst_head: got %h/%b want 0/0", m_axis_tdata, m_axis_tlast); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %b want 0", frame_done); end
        n_cmp++; if (frame_len !== 32'd0 || frame_count !== 16'd0 || stall_cycles !== 32'd0)
            begin n_fail++; $display("FAIL arst_stats: got %0d/%0d/%0d want 0/0/0", frame_len, frame_count, stall_cycles); end
        @(posedge clk);
        @(negedge clk);
        resetn = 1;
        model_reset();
        @(posedge clk);
        #1;
        s_valid = 1; s_data = 32'h0BAD_F00D; s_last = 1;
        tick();
        s_valid = 0;
        #2;
        n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0BAD_F00D)
            begin n_fail++; $display("FAIL arst_restart: got %b/%h want 1/0badf00d", m_axis_tvalid, m_axis_tdata); end
        tick();
        #2;
        n_cmp++; if (frame_len !== 32'd1 || frame_count !== 16'd1)
            begin n_fail++; $display("FAIL arst_restart_stats: got %0d/%0d want 1/1", frame_len, frame_count); end
    endtask

    initial begin
        resetn = 0;
        idle_inputs();
        test_reset();
        test_single();
        test_fill();
        test_full_simul();
        test_frame12();
        test_clear();
        test_random_stream();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
